// File: rtl/memory_stage_pkg.sv
// Shared core constants, state encodings and the execute-to-memory operand bundle.
package memory_stage_pkg;

    localparam logic [31:0] REGPC_NOP = 32'h0000_0000;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    localparam logic [3:0] MEN_X = 4'd0;
    localparam logic [3:0] MEN_S = 4'd1;
    localparam logic [3:0] MEN_L = 4'd2;

    localparam logic [3:0] WB_X  = 4'd0;
    localparam logic [2:0] CSR_X = 3'd0;

    localparam logic [2:0] LS_B  = 3'd0;
    localparam logic [2:0] LS_H  = 3'd1;
    localparam logic [2:0] LS_W  = 3'd2;
    localparam logic [2:0] LS_BU = 3'd4;
    localparam logic [2:0] LS_HU = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StWaitReady,
        StWaitValid,
        StDrain
    } mem_state_e;

    typedef struct packed {
        logic [31:0] reg_pc;
        logic [31:0] inst;
        logic [31:0] alu_out;
        logic [31:0] rs2_data;
        logic [31:0] op1_data;
        logic [31:0] imm_i;
        logic [3:0]  mem_wen;
        logic        rf_wen;
        logic [3:0]  wb_sel;
        logic [4:0]  wb_addr;
        logic [2:0]  csr_cmd;
        logic        jmp_flg;
    } ex_bundle_t;

    function automatic ex_bundle_t ex_nop();
        ex_bundle_t b;
        b         = '0;
        b.reg_pc  = REGPC_NOP;
        b.inst    = INST_NOP;
        b.mem_wen = MEN_X;
        b.wb_sel  = WB_X;
        b.csr_cmd = CSR_X;
        return b;
    endfunction

    // Drops the address bits below the access width.
    function automatic logic [1:0] force_align(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] r;
        r = lo;
        case (f3)
            LS_H, LS_HU: r = {lo[1], 1'b0};
            LS_W:        r = 2'b00;
            default:     r = lo;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane steering for stores, alignment check, and load extraction/extension.
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [4:0]  shamt;
    logic [31:0] r;

    assign shamt = {addr_lo, 3'b000};
    assign wdata = rs2 << shamt;
    assign r     = rdata >> shamt;

    always_comb begin
        wmask      = 4'b0000;
        misaligned = 1'b0;
        rdata_ext  = r;
        case (f3)
            LS_B: begin
                wmask     = 4'b0001 << addr_lo;
                rdata_ext = {{24{r[7]}}, r[7:0]};
            end
            LS_BU: begin
                wmask     = 4'b0001 << addr_lo;
                rdata_ext = {24'h0, r[7:0]};
            end
            LS_H: begin
                wmask      = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                rdata_ext  = {{16{r[15]}}, r[15:0]};
            end
            LS_HU: begin
                wmask      = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                rdata_ext  = {16'h0, r[15:0]};
            end
            LS_W: begin
                wmask      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on a ready/valid port, stalls execute,
// and registers results toward writeback.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_branch_hazard,
    input  logic [31:0] input_reg_pc,
    input  logic [31:0] input_inst,
    input  logic [31:0] input_alu_out,
    input  logic [31:0] input_rs2_data,
    input  logic [31:0] input_op1_data,
    input  logic [31:0] input_imm_i,
    input  logic [3:0]  input_mem_wen,
    input  logic        input_rf_wen,
    input  logic [3:0]  input_wb_sel,
    input  logic [4:0]  input_wb_addr,
    input  logic [2:0]  input_csr_cmd,
    input  logic        input_jmp_flg,
    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_cmd_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic [31:0] output_reg_pc,
    output logic [31:0] output_inst,
    output logic [31:0] output_alu_out,
    output logic [31:0] output_mem_rdata,
    output logic [31:0] output_op1_data,
    output logic [31:0] output_imm_i,
    output logic        output_rf_wen,
    output logic [3:0]  output_wb_sel,
    output logic [4:0]  output_wb_addr,
    output logic [2:0]  output_csr_cmd,
    output logic        output_jmp_flg,
    output logic        output_misaligned,
    output logic        memory_stage_stall_flg
);

    ex_bundle_t in_b, save_q, eff;
    logic       last_stall_q;
    mem_state_e state_q, state_d;

    logic [2:0]  f3;
    logic [1:0]  lane;
    logic        is_store, is_load, is_mem, mis, lsa_mis;
    logic [31:0] lsa_wdata, lsa_rdata;
    logic [3:0]  lsa_wmask;
    logic        start, stall, load_done;

    assign in_b = '{
        reg_pc:   input_reg_pc,
        inst:     input_inst,
        alu_out:  input_alu_out,
        rs2_data: input_rs2_data,
        op1_data: input_op1_data,
        imm_i:    input_imm_i,
        mem_wen:  input_mem_wen,
        rf_wen:   input_rf_wen,
        wb_sel:   input_wb_sel,
        wb_addr:  input_wb_addr,
        csr_cmd:  input_csr_cmd,
        jmp_flg:  input_jmp_flg
    };

    // Execute emits bubbles while we stall, so the held instruction lives in save_q.
    assign eff = last_stall_q ? save_q : in_b;

    assign f3       = eff.inst[14:12];
    assign is_store = (eff.mem_wen == MEN_S);
    assign is_load  = (eff.mem_wen == MEN_L);
    assign is_mem   = is_store | is_load;
    assign lane     = (CHECK_ALIGN != 0) ? eff.alu_out[1:0] : force_align(f3, eff.alu_out[1:0]);
    assign mis      = is_mem && (CHECK_ALIGN != 0) && lsa_mis;

    load_store_align u_align (
        .f3         (f3),
        .addr_lo    (lane),
        .rs2        (eff.rs2_data),
        .rdata      (mem_rdata),
        .wdata      (lsa_wdata),
        .wmask      (lsa_wmask),
        .misaligned (lsa_mis),
        .rdata_ext  (lsa_rdata)
    );

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        stall     = 1'b0;
        load_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_mem && !mis && !wb_branch_hazard) begin
                    start = 1'b1;
                    if (is_store) begin
                        if (!mem_cmd_ready) begin
                            stall   = 1'b1;
                            state_d = StWaitReady;
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = mem_cmd_ready ? StWaitValid : StWaitReady;
                    end
                end
            end
            StWaitReady: begin
                start = 1'b1;
                if (mem_cmd_ready) begin
                    if (is_store) begin
                        state_d = StIdle;
                    end else begin
                        stall   = 1'b1;
                        state_d = wb_branch_hazard ? StDrain : StWaitValid;
                    end
                end else begin
                    stall = 1'b1;
                    if (wb_branch_hazard) state_d = StIdle;
                end
            end
            StWaitValid: begin
                if (mem_rdata_valid) begin
                    load_done = 1'b1;
                    state_d   = StIdle;
                end else begin
                    stall = 1'b1;
                    if (wb_branch_hazard) state_d = StDrain;
                end
            end
            StDrain: begin
                stall = 1'b1;
                if (mem_rdata_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_cmd_start          = start;
    assign mem_cmd_write          = is_store;
    assign mem_addr               = {eff.alu_out[31:2], 2'b00};
    assign mem_wdata              = lsa_wdata;
    assign mem_wmask              = lsa_wmask;
    assign memory_stage_stall_flg = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            save_q       <= ex_nop();
            last_stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wb_branch_hazard) begin
                save_q       <= ex_nop();
                last_stall_q <= 1'b0;
            end else begin
                last_stall_q <= stall;
                if (stall) save_q <= eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            output_reg_pc     <= REGPC_NOP;
            output_inst       <= INST_NOP;
            output_alu_out    <= '0;
            output_mem_rdata  <= '0;
            output_op1_data   <= '0;
            output_imm_i      <= '0;
            output_rf_wen     <= 1'b0;
            output_wb_sel     <= '0;
            output_wb_addr    <= '0;
            output_csr_cmd    <= '0;
            output_jmp_flg    <= 1'b0;
            output_misaligned <= 1'b0;
        end else if (wb_branch_hazard || stall) begin
            output_reg_pc     <= REGPC_NOP;
            output_inst       <= INST_NOP;
            output_alu_out    <= 32'hffff_ffff;
            output_mem_rdata  <= 32'hffff_ffff;
            output_op1_data   <= 32'hffff_ffff;
            output_imm_i      <= 32'hffff_ffff;
            output_rf_wen     <= 1'b0;
            output_wb_sel     <= WB_X;
            output_wb_addr    <= '0;
            output_csr_cmd    <= CSR_X;
            output_jmp_flg    <= 1'b0;
            output_misaligned <= 1'b0;
        end else begin
            output_reg_pc     <= eff.reg_pc;
            output_inst       <= eff.inst;
            output_alu_out    <= eff.alu_out;
            output_mem_rdata  <= load_done ? lsa_rdata : '0;
            output_op1_data   <= eff.op1_data;
            output_imm_i      <= eff.imm_i;
            output_rf_wen     <= eff.rf_wen && !mis;
            output_wb_sel     <= eff.wb_sel;
            output_wb_addr    <= eff.wb_addr;
            output_csr_cmd    <= eff.csr_cmd;
            output_jmp_flg    <= eff.jmp_flg;
            output_misaligned <= mis;
        end
    end

endmodule
